// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmit AXI-Stream among N_REQ byte sources.
// A grant is held until tlast, a MAX_BURST beat limit, or an idle timeout, so messages stay contiguous.
module uart_tx_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16,
    parameter int TIMEOUT    = 64,
    parameter int ID_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [N_REQ-1:0]            s_axis_tvalid,
    input  logic [N_REQ-1:0]            s_axis_tlast,
    output logic [N_REQ-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [ID_W-1:0]             m_axis_tid,
    output logic [N_REQ-1:0]            grant,
    output logic                        busy,
    output logic                        timeout_evt
);

    localparam int BEAT_W    = $clog2(MAX_BURST + 1);
    localparam int IDLE_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int IDLE_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_gnt_idx;
    logic [N_REQ-1:0]    r_grant;
    logic                r_busy;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [IDLE_W-1:0]   r_idle_cnt;

    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic                  w_req_found;
    logic [ID_W-1:0]       w_req_idx;
    logic [ID_W-1:0]       w_cand;
    logic [ID_W-1:0]       w_next_ptr;
    logic                  w_hs;
    logic                  w_timeout;
    logic                  w_release;

    // Granted source routed straight through; grant is all-zero outside LOCK, so the mux is too.
    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant[i]) begin
                w_sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_valid = s_axis_tvalid[i];
                w_sel_last  = s_axis_tlast[i];
            end
        end
    end

    // First requester at or after r_ptr, wrapping around.
    always_comb begin
        w_req_found = 1'b0;
        w_req_idx   = '0;
        w_cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = ID_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_req_found && s_axis_tvalid[w_cand]) begin
                w_req_found = 1'b1;
                w_req_idx   = w_cand;
            end
        end
    end

    // A beat moves when valid and ready are both high on a rising edge; valid never waits on ready,
    // and a source holds valid and data until its beat is accepted.
    assign w_hs       = w_sel_valid & m_axis_tready;
    assign w_next_ptr = (r_gnt_idx == ID_W'(N_REQ - 1)) ? '0 : r_gnt_idx + ID_W'(1);
    // A timeout needs valid low, so a handshake always wins and suppresses timeout_evt.
    assign w_timeout  = (TIMEOUT != 0) && r_busy && !w_sel_valid
                        && (r_idle_cnt == IDLE_W'(IDLE_LAST));
    assign w_release  = (w_hs && (w_sel_last || (r_beat_cnt == BEAT_W'(MAX_BURST - 1))))
                        || w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_gnt_idx  <= '0;
            r_grant    <= '0;
            r_busy     <= 1'b0;
            r_beat_cnt <= '0;
            r_idle_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req_found) begin
                        r_state    <= S_LOCK;
                        r_gnt_idx  <= w_req_idx;
                        r_grant    <= N_REQ'(1) << w_req_idx;
                        r_busy     <= 1'b1;
                        r_beat_cnt <= '0;
                        r_idle_cnt <= '0;
                    end
                end
                S_LOCK: begin
                    if (w_release) begin
                        r_state    <= S_IDLE;
                        r_ptr      <= w_next_ptr;
                        r_gnt_idx  <= '0;
                        r_grant    <= '0;
                        r_busy     <= 1'b0;
                        r_beat_cnt <= '0;
                        r_idle_cnt <= '0;
                    end else begin
                        if (w_hs && (r_beat_cnt != '1)) begin
                            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                        end
                        if (w_sel_valid) begin
                            r_idle_cnt <= '0;
                        end else if (r_idle_cnt != '1) begin
                            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_axis_tready = r_grant & {N_REQ{m_axis_tready}};
    assign m_axis_tdata  = w_sel_data;
    assign m_axis_tvalid = w_sel_valid;
    assign m_axis_tid    = r_gnt_idx;
    assign grant         = r_grant;
    assign busy          = r_busy;
    assign timeout_evt   = w_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios pinned by literal expectations, then random
// traffic checked every cycle against a behavioural arbitration model and per-requester data queues.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int MB    = 16;
  localparam int TO    = 64;
  localparam int IDW   = 2;
  localparam int LOG_N = 200;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic [IDW-1:0]  m_tid;
  logic [N-1:0]    grant;
  logic            busy;
  logic            tevt;

  uart_tx_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tid(m_tid), .grant(grant), .busy(busy), .timeout_evt(tevt)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // sources and scoreboard: entries are {last, data}
  logic [DW:0]      src_q [N][$];
  logic [DW:0]      exp_q [N][$];
  int unsigned      pause [N];
  int unsigned      gap_pct = 0;
  logic [N-1:0]     hs_now;

  // behavioural model: owner -1 means no grant held
  int owner = -1;
  int ptr = 0;
  int beats = 0;
  int idle = 0;

  // per-cycle trace of the current scenario
  logic [N-1:0]      lg_grant [LOG_N];
  logic [N-1:0]      lg_srdy  [LOG_N];
  logic              lg_mv    [LOG_N];
  logic              lg_tevt  [LOG_N];
  logic [DW-1:0]     lg_data  [LOG_N];
  logic [IDW+DW-1:0] hs_log   [$];
  logic [IDW+DW-1:0] exp_seq  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_pkt(input int r, input int len, input logic [DW-1:0] base, input bit with_last);
    for (int i = 0; i < len; i++) begin
      logic [DW:0] e;
      e = {(with_last && (i == len - 1)), base + DW'(i)};
      src_q[r].push_back(e);
      exp_q[r].push_back(e);
    end
  endtask

  task automatic exp_beat(input int tid, input logic [DW-1:0] d);
    exp_seq.push_back({IDW'(tid), d});
  endtask

  task automatic cmp_seq(input string name);
    logic [IDW+DW-1:0] a;
    chk({name, "_len"}, hs_log.size(), exp_seq.size());
    for (int k = 0; k < exp_seq.size(); k++) begin
      a = (k < hs_log.size()) ? hs_log[k] : '1;
      chk(name, a, exp_seq[k]);
    end
    exp_seq.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tid", m_tid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_timeout_evt", tevt, 0);
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
      pause[i] = 0;
    end
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b1;
    hs_now   = '0;
    owner = -1; ptr = 0; beats = 0; idle = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc = 0;
    hs_log.delete();
  endtask

  // driver: a source keeps valid until its beat is taken, then may gap or pause
  task automatic drive_inputs(input logic rdy);
    logic v;
    for (int i = 0; i < N; i++) begin
      if (s_tvalid[i] && !hs_now[i]) v = 1'b1;
      else if (src_q[i].size() == 0) v = 1'b0;
      else if (pause[i] != 0) begin
        v = 1'b0;
        pause[i]--;
      end else v = ($urandom_range(99) >= gap_pct);
      s_tvalid[i] = v;
      s_tdata[i*DW +: DW] = (src_q[i].size() != 0) ? src_q[i][0][DW-1:0] : '0;
      s_tlast[i] = (src_q[i].size() != 0) ? src_q[i][0][DW] : 1'b0;
    end
    m_tready = rdy;
  endtask

  // compare process: outputs versus model, scoreboard on accepted beats, then model advance
  task automatic model_check();
    logic [N-1:0] one, e_grant, e_rdy;
    logic e_busy, e_mv, e_to, hs, rel;
    logic [DW:0] front;
    int g;
    bit found;
    one = 1;
    e_busy = (owner >= 0);
    g = e_busy ? owner : 0;
    e_grant = e_busy ? (one << g) : '0;
    e_mv = e_busy && s_tvalid[g];
    e_rdy = (e_busy && m_tready) ? e_grant : '0;
    hs = e_mv && m_tready;
    e_to = e_busy && !e_mv && (idle + 1 == TO);
    chk("busy", busy, e_busy);
    chk("grant", grant, e_grant);
    chk("m_tvalid", m_tvalid, e_mv);
    chk("s_tready", s_tready, e_rdy);
    chk("timeout_evt", tevt, e_to);
    if (e_busy) begin
      chk("m_tid", m_tid, g);
      chk("m_tdata", m_tdata, s_tdata[g*DW +: DW]);
    end
    if (m_tvalid && m_tready) begin
      hs_log.push_back({m_tid, m_tdata});
      chk("sb_pending", exp_q[m_tid].size() != 0, 1);
      if (exp_q[m_tid].size() != 0) begin
        front = exp_q[m_tid].pop_front();
        chk("sb_data", m_tdata, front[DW-1:0]);
      end
    end
    hs_now = s_tvalid & s_tready;
    if (cyc < LOG_N) begin
      lg_grant[cyc] = grant;
      lg_srdy[cyc]  = s_tready;
      lg_mv[cyc]    = m_tvalid;
      lg_tevt[cyc]  = tevt;
      lg_data[cyc]  = m_tdata;
    end
    if (!e_busy) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && s_tvalid[(ptr + k) % N]) begin
          found = 1'b1;
          owner = (ptr + k) % N;
        end
      end
      beats = 0;
      idle = 0;
    end else begin
      rel = (hs && (s_tlast[g] || (beats + 1 == MB))) || e_to;
      if (rel) begin
        ptr = (owner + 1) % N;
        owner = -1;
      end else begin
        if (hs) beats++;
        idle = e_mv ? 0 : idle + 1;
      end
    end
  endtask

  task automatic finish_cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs_now[i]) void'(src_q[i].pop_front());
    cyc++;
  endtask

  task automatic cycle(input logic rdy);
    drive_inputs(rdy);
    finish_cycle();
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  initial begin
    int ord[6];
    int tcount;
    int n;
    ord = '{0, 1, 2, 3, 0, 1};
    #2;

    // single 3-beat message from req0
    do_reset();
    push_pkt(0, 3, 8'h41, 1);
    repeat (8) cycle(1'b1);
    chk("s1_mv1", lg_mv[1], 1); chk("s1_d1", lg_data[1], 8'h41);
    chk("s1_mv2", lg_mv[2], 1); chk("s1_d2", lg_data[2], 8'h42);
    chk("s1_mv3", lg_mv[3], 1); chk("s1_d3", lg_data[3], 8'h43);
    chk("s1_g3", lg_grant[3], 4'b0001);
    chk("s1_bubble", lg_grant[4], 4'b0000);
    chk("s1_mv4", lg_mv[4], 0);
    exp_beat(0, 8'h41); exp_beat(0, 8'h42); exp_beat(0, 8'h43);
    cmp_seq("s1_seq");

    // all four send single-beat packets: rotation with a bubble between grants
    do_reset();
    push_pkt(0, 1, 8'hA0, 1); push_pkt(0, 1, 8'hA1, 1);
    push_pkt(1, 1, 8'hB0, 1); push_pkt(1, 1, 8'hB1, 1);
    push_pkt(2, 1, 8'hC0, 1); push_pkt(3, 1, 8'hD0, 1);
    repeat (16) cycle(1'b1);
    for (int k = 0; k < 6; k++) begin
      chk("s2_grant", lg_grant[2*k+1], 4'b0001 << ord[k]);
      chk("s2_bubble", lg_grant[2*k+2], 4'b0000);
    end

    // req1 20 beats without tlast, req2 waiting: split at 16
    do_reset();
    push_pkt(1, 20, 8'h10, 0);
    push_pkt(2, 2, 8'hE0, 1);
    repeat (100) cycle(1'b1);
    for (int k = 0; k < 16; k++) exp_beat(1, 8'h10 + 8'(k));
    exp_beat(2, 8'hE0); exp_beat(2, 8'hE1);
    for (int k = 16; k < 20; k++) exp_beat(1, 8'h10 + 8'(k));
    cmp_seq("s3_seq");
    chk("s3_bubble", lg_grant[17], 4'b0000);
    chk("s3_req2", lg_grant[18], 4'b0100);
    chk("s3_tevt", lg_tevt[88], 1);

    // req0 one beat then stalls with req3 pending: timeout release
    do_reset();
    push_pkt(0, 1, 8'h55, 0);
    push_pkt(3, 1, 8'h77, 1);
    repeat (75) cycle(1'b1);
    tcount = 0;
    for (int c = 0; c < 75; c++) if (lg_tevt[c]) tcount++;
    chk("s4_tevt_count", tcount, 1);
    chk("s4_tevt_at", lg_tevt[65], 1);
    chk("s4_held", lg_grant[65], 4'b0001);
    chk("s4_bubble", lg_grant[66], 4'b0000);
    chk("s4_req3", lg_grant[67], 4'b1000);
    exp_beat(0, 8'h55); exp_beat(3, 8'h77);
    cmp_seq("s4_seq");

    // downstream not ready for 10 cycles mid-packet
    do_reset();
    push_pkt(2, 5, 8'h30, 1);
    for (int c = 0; c < 20; c++) cycle(!(c >= 3 && c <= 12));
    for (int c = 3; c <= 12; c++) begin
      chk("s5_mv_hold", lg_mv[c], 1);
      chk("s5_data_hold", lg_data[c], 8'h32);
      chk("s5_srdy", lg_srdy[c], 4'b0000);
    end
    for (int k = 0; k < 5; k++) exp_beat(2, 8'h30 + 8'(k));
    cmp_seq("s5_seq");

    // reset mid-packet, then ptr restarts at 0
    do_reset();
    push_pkt(1, 5, 8'h60, 1);
    repeat (3) cycle(1'b1);
    exp_beat(1, 8'h60); exp_beat(1, 8'h61);
    cmp_seq("s6_pre");
    drive_inputs(1'b1);
    do_reset();
    push_pkt(2, 1, 8'h90, 1);
    push_pkt(0, 1, 8'h80, 1);
    repeat (6) cycle(1'b1);
    chk("s6_req0_first", lg_grant[1], 4'b0001);
    exp_beat(0, 8'h80); exp_beat(2, 8'h90);
    cmp_seq("s6_seq");

    // random traffic
    do_reset();
    gap_pct = 25;
    for (int c = 0; c < 4000; c++) begin
      for (int r = 0; r < N; r++) begin
        if (src_q[r].size() < 30 && $urandom_range(99) < 4)
          push_pkt(r, $urandom_range(20, 1), 8'($urandom), $urandom_range(3) != 0);
        if ($urandom_range(999) < 3) pause[r] = 70;
      end
      cycle($urandom_range(99) < 80);
    end
    gap_pct = 0;
    for (int r = 0; r < N; r++) pause[r] = 0;
    n = 0;
    while (pending() && n < 3000) begin
      cycle(1'b1);
      n++;
    end
    repeat (70) cycle(1'b1);
    for (int r = 0; r < N; r++) chk("drain_empty", exp_q[r].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
